fric_master_sequencer: RTL and testbench

//  Command sequencer that sits directly upstream of fric_client_master and drives its transaction interface.
//  It buffers queued FRIc read/write commands in a FIFO and issues them one at a time (ctyp/port/addr/wdat/tstb).
//  For reads it waits for rstb/rdat and returns the data, or a timeout error, on a valid/ready response port.

---
 rtl/fric_master_sequencer_if.sv | 20 ++
 rtl/fric_master_sequencer.sv | 151 +++++++++++++++
 tb/tb_fric_master_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fric_master_sequencer_if.sv
// fric_master_sequencer_if
//   Transaction bus between the command sequencer and fric_client_master.
//   ctyp/port/addr/wdat : transaction fields, driven by the sequencer
//   tstb                : one-cycle transaction strobe, driven by the sequencer
//   trdy                : master ready to accept a transaction
//   rstb/rdat           : one-cycle read-data strobe and read data from the master
//   modport master : sequencer side; modport slave : fric_client_master side
interface fric_master_sequencer_if;
  logic [3:0]  ctyp;
  logic [3:0]  port;
  logic [7:0]  addr;
  logic [15:0] wdat;
  logic        tstb;
  logic        trdy;
  logic        rstb;
  logic [15:0] rdat;

  modport master (output ctyp, port, addr, wdat, tstb, input trdy, rstb, rdat);
  modport slave  (input ctyp, port, addr, wdat, tstb, output trdy, rstb, rdat);
endinterface

// File: rtl/fric_master_sequencer.sv
// fric_master_sequencer
//   Buffers FRIc read/write commands in a FIFO and issues them one at a time
//   to fric_client_master. Reads wait for rstb/rdat (or a timeout) and return
//   the result on a valid/ready response port. Writes produce no response.
// Ports
//   clk, rst              : clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (cmd_ready = FIFO not full)
//   cmd_rd/port/addr/wdat : command fields (1 = read)
//   bus                   : transaction bus to fric_client_master (master modport)
//   rsp_valid/rsp_ready   : read response handshake
//   rsp_data/rsp_err      : read data (0 on timeout), timeout flag
//   busy                  : FIFO non-empty or a transaction in progress
//   tmo_count             : saturating count of read timeouts
module fric_master_sequencer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [3:0]  CTYP_WR   = 4'h0,
  parameter logic [3:0]  CTYP_RD   = 4'h2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_rd,
  input  logic [3:0]                     cmd_port,
  input  logic [7:0]                     cmd_addr,
  input  logic [15:0]                    cmd_wdat,
  fric_master_sequencer_if.master        bus,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [15:0]                    rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [7:0]                     tmo_count
);

  localparam int unsigned PW       = $clog2(CMD_DEPTH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RSP} state_t;

  state_t        state;
  logic [28:0]   mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic [28:0]   head;
  logic          cur_rd;
  logic [15:0]   timer;

  // Depth is a power of two, so the occupancy MSB alone marks full.
  assign full      = count[PW];
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);

  // The strobe must coincide with a trdy cycle, so it is the registered
  // ISSUE state qualified by the live trdy rather than a separate flop.
  assign bus.tstb  = (state == ISSUE) && bus.trdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_rd, cmd_port, cmd_addr, cmd_wdat};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus.ctyp  <= '0;
      bus.port  <= '0;
      bus.addr  <= '0;
      bus.wdat  <= '0;
      cur_rd    <= 1'b0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      tmo_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.ctyp <= head[28] ? CTYP_RD : CTYP_WR;
            bus.port <= head[27:24];
            bus.addr <= head[23:16];
            bus.wdat <= head[15:0];
            cur_rd   <= head[28];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.trdy) begin
            if (cur_rd) begin
              timer <= '0;
              state <= RWAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        RWAIT: begin
          // rstb wins over a timeout landing on the same cycle.
          if (bus.rstb) begin
            rsp_data  <= bus.rdat;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else if (timer == TMO_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (tmo_count != '1) tmo_count <= tmo_count + 8'd1;
            state     <= RSP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fric_master_sequencer.sv
// tb_fric_master_sequencer
//   Directed bench for fric_master_sequencer (CMD_DEPTH=4, TIMEOUT=8).
//   Expected transactions and responses are queued as stimulus is issued and
//   compared by a monitor whenever the DUT strobes tstb or completes a
//   response handshake.
module tb_fric_master_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [3:0]  cmd_port;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] rsp_data;
  logic [7:0]  tmo_count;

  fric_master_sequencer_if bus ();

  fric_master_sequencer #(
    .CMD_DEPTH(4), .TIMEOUT(8), .CTYP_WR(4'h0), .CTYP_RD(4'h2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat),
    .bus(bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tmo_count(tmo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctyp;
    logic [3:0]  port;
    logic [7:0]  addr;
    logic [15:0] wdat;
    logic        chk_wdat;
  } iss_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  iss_t mon_iss;
  rsp_t mon_rsp;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobe and every response handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.tstb) begin
        chk("iss_expected", 32'(exp_iss.size() != 0), 32'd1);
        if (exp_iss.size() != 0) begin
          mon_iss = exp_iss.pop_front();
          chk("iss_ctyp", 32'(bus.ctyp), 32'(mon_iss.ctyp));
          chk("iss_port", 32'(bus.port), 32'(mon_iss.port));
          chk("iss_addr", 32'(bus.addr), 32'(mon_iss.addr));
          if (mon_iss.chk_wdat) chk("iss_wdat", 32'(bus.wdat), 32'(mon_iss.wdat));
        end
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) begin
          mon_rsp = exp_rsp.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(mon_rsp.data));
          chk("rsp_err", 32'(rsp_err), 32'(mon_rsp.err));
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push(input logic rd, input logic [3:0] p, input logic [7:0] a, input logic [15:0] d);
    int unsigned n = 0;
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_port  = p;
    cmd_addr  = a;
    cmd_wdat  = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("push_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    exp_iss.push_back(iss_t'{ctyp: (rd ? 4'h2 : 4'h0), port: p, addr: a, wdat: d, chk_wdat: !rd});
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the strobe cycle.
  task automatic wait_tstb(input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!bus.tstb && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tstb) chk({name, "_tstb_timeout"}, 32'(bus.tstb), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_tstb"},      32'(bus.tstb),  32'd0);
    chk({tag, "_ctyp"},      32'(bus.ctyp),  32'd0);
    chk({tag, "_port"},      32'(bus.port),  32'd0);
    chk({tag, "_addr"},      32'(bus.addr),  32'd0);
    chk({tag, "_wdat"},      32'(bus.wdat),  32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_tmo_count"}, 32'(tmo_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_port = '0; cmd_addr = '0; cmd_wdat = '0;
    rsp_ready = 1'b1;
    bus.trdy = 1'b1; bus.rstb = 1'b0; bus.rdat = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: single write, no response expected
    push(1'b0, 4'd1, 8'h10, 16'hBEEF);
    wait_idle("t1");
    chk("t1_no_rsp", 32'(rsp_valid), 32'd0);

    // 2: read answered 5 cycles after the strobe
    push(1'b1, 4'd1, 8'h22, 16'h0000);
    wait_tstb("t2");
    repeat (5) @(posedge clk);
    #1;
    bus.rstb = 1'b1; bus.rdat = 16'h1234;
    exp_rsp.push_back(rsp_t'{data: 16'h1234, err: 1'b0});
    @(posedge clk);
    #1;
    bus.rstb = 1'b0;
    wait_idle("t2");
    chk("t2_rsp_drained", 32'(exp_rsp.size()), 32'd0);

    // 3: read timeout after 8 wait cycles, late rstb discarded
    rsp_ready = 1'b0;
    push(1'b1, 4'd2, 8'h33, 16'h0000);
    wait_tstb("t3");
    exp_rsp.push_back(rsp_t'{data: 16'h0000, err: 1'b1});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_no_early_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rsp_err",   32'(rsp_err),   32'd1);
    chk("t3_rsp_data",  32'(rsp_data),  32'd0);
    chk("t3_tmo_count", 32'(tmo_count), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle("t3");
    bus.rstb = 1'b1; bus.rdat = 16'hDEAD;
    @(posedge clk);
    #1;
    bus.rstb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_late_rstb_valid", 32'(rsp_valid), 32'd0);
      chk("t3_late_rstb_busy",  32'(busy),      32'd0);
    end
    chk("t3_tmo_count_hold", 32'(tmo_count), 32'd1);
    @(posedge clk);
    #1;

    // 4: backpressure holds fields for 10 cycles, then strobes on trdy
    bus.trdy = 1'b0;
    push(1'b0, 4'd3, 8'h44, 16'hA5A5);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_tstb_low", 32'(bus.tstb), 32'd0);
      chk("t4_ctyp",     32'(bus.ctyp), 32'h0);
      chk("t4_port",     32'(bus.port), 32'h3);
      chk("t4_addr",     32'(bus.addr), 32'h44);
      chk("t4_wdat",     32'(bus.wdat), 32'hA5A5);
    end
    @(posedge clk);
    #1;
    bus.trdy = 1'b1;
    @(negedge clk);
    chk("t4_tstb_fire", 32'(bus.tstb), 32'd1);
    wait_idle("t4");

    // 5: fill the FIFO behind a stalled head, then drain in order
    bus.trdy = 1'b0;
    push(1'b0, 4'd4, 8'h50, 16'h1111);
    push(1'b0, 4'd5, 8'h51, 16'h2222);
    push(1'b0, 4'd6, 8'h52, 16'h3333);
    push(1'b0, 4'd7, 8'h53, 16'h4444);
    chk("t5_ready_after4", 32'(cmd_ready), 32'd1);
    push(1'b0, 4'd8, 8'h54, 16'h5555);
    chk("t5_full", 32'(cmd_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    bus.trdy = 1'b1;
    wait_idle("t5");
    chk("t5_drained", 32'(exp_iss.size()), 32'd0);
    chk("t5_ready_again", 32'(cmd_ready), 32'd1);

    // 6a: reset during RWAIT
    push(1'b1, 4'd5, 8'h66, 16'h0000);
    wait_tstb("t6a");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset("t6a");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 6b: reset while a response is held by rsp_ready=0
    rsp_ready = 1'b0;
    push(1'b1, 4'd6, 8'h77, 16'h0000);
    wait_tstb("t6b");
    @(posedge clk);
    #1;
    bus.rstb = 1'b1; bus.rdat = 16'h5A5A;
    @(posedge clk);
    #1;
    bus.rstb = 1'b0;
    @(negedge clk);
    chk("t6b_rsp_held", 32'(rsp_valid), 32'd1);
    chk("t6b_rsp_data", 32'(rsp_data), 32'h5A5A);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset("t6b");
    @(posedge clk);
    #1;
    rst = 1'b1;
    rsp_ready = 1'b1;

    // Operation resumes normally after reset
    push(1'b0, 4'd9, 8'h99, 16'hC0DE);
    wait_idle("post");
    chk("end_iss_empty", 32'(exp_iss.size()), 32'd0);
    chk("end_rsp_empty", 32'(exp_rsp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
